// File: rtl/pool_ctrl.sv
// pool_ctrl: control sequencer for the pooling stage. Walks one feature-map
// plane per start, emitting one registered ctrl word per accepted element.
// Optional bottom-edge padding row is compiled in with POOL_CTRL_PAD_EN.
// Ports: clk, reset (sync, active-high); start/cfg/row_width/num_rows set up
// a plane; data_valid/data_ready upstream handshake; pool_ready downstream
// backpressure; ctrl = {pool_pad_row, pool_valid, row_fifo_mux_sel,
// row_fifo_pop, row_fifo_push, pop, shift}; ready in IDLE; done pulse at end.
module pool_ctrl #(
    parameter int CTRL_WIDTH      = 7,
    parameter int CFG_WIDTH       = 3,
    parameter int ROW_COUNT_WIDTH = 6,
    parameter int DRAIN_CYCLES    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CFG_WIDTH-1:0]       cfg,
    input  logic [ROW_COUNT_WIDTH-1:0] row_width,
    input  logic [ROW_COUNT_WIDTH-1:0] num_rows,
    input  logic                       data_valid,
    output logic                       data_ready,
    input  logic                       pool_ready,
    output logic [CTRL_WIDTH-1:0]      ctrl,
    output logic                       ready,
    output logic                       done
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [ROW_COUNT_WIDTH-1:0] ONE = ROW_COUNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
`ifdef POOL_CTRL_PAD_EN
        PAD,
`endif
        DRAIN,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic                       k3_q, k3_d;
    logic [1:0]                 sm1_q, sm1_d;
    logic [ROW_COUNT_WIDTH-1:0] w_q, w_d, h_q, h_d;
    logic [ROW_COUNT_WIDTH-1:0] col_q, col_d, row_q, row_d;
    // Stride down-counters: zero means the current index closes a window
    // along that axis; they start at K-1 and reload with S-1.
    logic [1:0]                 csd_q, csd_d, rsd_q, rsd_d;
    logic [DW-1:0]              drain_q, drain_d;
    logic [CTRL_WIDTH-1:0]      ctrl_q, ctrl_d;

    logic       pv;
    logic       last_col;
    logic [1:0] km1;

    assign pv       = (rsd_q == 2'd0) && (csd_q == 2'd0);
    assign last_col = (col_q == w_q - ONE);
    assign km1      = k3_q ? 2'd2 : 2'd1;

    always_comb begin
        state_d    = state_q;
        k3_d       = k3_q;
        sm1_d      = sm1_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        csd_d      = csd_q;
        rsd_d      = rsd_q;
        drain_d    = drain_q;
        ctrl_d     = '0;
        data_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    k3_d  = cfg[0];
                    sm1_d = (cfg[2:1] == 2'd0) ? 2'd0 : cfg[2:1] - 2'd1;
                    w_d   = row_width;
                    h_d   = num_rows;
                    col_d = '0;
                    row_d = '0;
                    csd_d = cfg[0] ? 2'd2 : 2'd1;
                    rsd_d = cfg[0] ? 2'd2 : 2'd1;
                    // Empty plane: one settle cycle, then the done pulse.
                    if (row_width == '0 || num_rows == '0) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LAST;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                data_ready = pool_ready;
                if (data_valid && pool_ready) begin
                    ctrl_d = {1'b0, pv, row_q != '0, row_q != '0,
                              row_q != h_q - ONE, pv, 1'b1};
                    if (last_col) begin
                        col_d = '0;
                        csd_d = km1;
                        rsd_d = (rsd_q == 2'd0) ? sm1_q : rsd_q - 2'd1;
                        if (row_q == h_q - ONE) begin
                            row_d   = '0;
                            drain_d = '0;
`ifdef POOL_CTRL_PAD_EN
                            state_d = PAD;
`else
                            state_d = DRAIN;
`endif
                        end else begin
                            row_d = row_q + ONE;
                        end
                    end else begin
                        col_d = col_q + ONE;
                        csd_d = (csd_q == 2'd0) ? sm1_q : csd_q - 2'd1;
                    end
                end
            end
`ifdef POOL_CTRL_PAD_EN
            // Virtual row H: rsd_q already holds the row phase for index H.
            PAD: begin
                if (pool_ready) begin
                    ctrl_d = {1'b1, pv, 1'b1, 1'b1, 1'b0, pv, 1'b1};
                    if (last_col) begin
                        col_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        col_d = col_q + ONE;
                        csd_d = (csd_q == 2'd0) ? sm1_q : csd_q - 2'd1;
                    end
                end
            end
`endif
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k3_q    <= 1'b0;
            sm1_q   <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            csd_q   <= '0;
            rsd_q   <= '0;
            drain_q <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            k3_q    <= k3_d;
            sm1_q   <= sm1_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            row_q   <= row_d;
            csd_q   <= csd_d;
            rsd_q   <= rsd_d;
            drain_q <= drain_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ctrl  = ctrl_q;
    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);

endmodule
